pagerank_damp_finalize: RTL

//  Second-generation PageRank finalize stage. Accepts one contribution vector per HW thread

---
 rtl/pagerank_pkg.sv | 35 +++
 rtl/pagerank_damp_lane.sv | 39 +++
 rtl/pagerank_damp_finalize.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pagerank_pkg.sv
// Shared types and helpers for the PageRank finalize stage: state enum, Q-format
// constant builders and wide saturating/absolute-difference arithmetic.
package pagerank_pkg;

    localparam int MAX_W = 256;

    typedef logic [MAX_W-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DAMP,
        DONE
    } state_e;

    function automatic wide_t one_val(input int unsigned frac_w);
        return wide_t'(1) << frac_w;
    endfunction

    // Uniform initial rank ONE/N, truncated toward zero.
    function automatic wide_t recip_n(input int unsigned frac_w, input int unsigned n);
        return one_val(frac_w) / wide_t'(n);
    endfunction

    function automatic wide_t abs_diff(input wide_t a, input wide_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic wide_t sat(input wide_t v, input int unsigned w);
        wide_t lim;
        lim = (wide_t'(1) << w) - wide_t'(1);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/pagerank_damp_lane.sv
// Combinational damping lane: new = BASE + ((d*acc)>>FRAC_W) saturated to DATA_W,
// plus |new - old| for the convergence delta. Time-shared across nodes by the top.
module pagerank_damp_lane
    import pagerank_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int FRAC_W         = 32,
    parameter int ACC_W          = 67,
    parameter int NODES_IN_GRAPH = 32
) (
    input  logic [DATA_W-1:0] damp,
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] old_rank,
    output logic [DATA_W-1:0] new_rank,
    output logic [DATA_W-1:0] diff
);

    localparam int PROD_W = DATA_W + ACC_W;
    localparam logic [DATA_W-1:0] ONE_D   = DATA_W'(one_val(FRAC_W));
    localparam logic [DATA_W-1:0] RECIP_D = DATA_W'(recip_n(FRAC_W, NODES_IN_GRAPH));

    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   scaled;
    logic [2*DATA_W-1:0] base_prod;
    logic [2*DATA_W-1:0] base_full;
    wide_t               sum_w;

    // damp is already clamped to ONE upstream, so ONE - damp never underflows.
    always_comb begin
        prod      = {{ACC_W{1'b0}}, damp} * {{DATA_W{1'b0}}, acc};
        scaled    = prod >> FRAC_W;
        base_prod = {{DATA_W{1'b0}}, ONE_D - damp} * {{DATA_W{1'b0}}, RECIP_D};
        base_full = base_prod >> FRAC_W;
        sum_w     = sat(wide_t'(scaled) + wide_t'(base_full), DATA_W);
        new_rank  = DATA_W'(sum_w);
        diff      = DATA_W'(abs_diff(wide_t'(new_rank), wide_t'(old_rank)));
    end

endmodule

// File: rtl/pagerank_damp_finalize.sv
// PageRank finalize stage: sums per-partition contribution beats, damps one node per
// cycle into the stored rank vector, and tracks L1 delta against a convergence threshold.
module pagerank_damp_finalize
    import pagerank_pkg::*;
#(
    parameter int NUM_HW_THREADS = 8,
    parameter int NODES_IN_GRAPH = 32,
    parameter int DATA_W         = 64,
    parameter int FRAC_W         = 32,
    parameter int ITER_W         = 16
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      iter_start,
    input  logic [DATA_W-1:0]                         damping_factor,
    input  logic [DATA_W+$clog2(NODES_IN_GRAPH)-1:0]  epsilon,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [DATA_W-1:0]                         in_data [NODES_IN_GRAPH],
    output logic [DATA_W-1:0]                         pagerank_final [NODES_IN_GRAPH],
    output logic [DATA_W+$clog2(NODES_IN_GRAPH)-1:0]  delta,
    output logic                                      converged,
    output logic                                      iteration_complete,
    output logic [ITER_W-1:0]                         iter_count
);

    localparam int ACC_W   = DATA_W + $clog2(NUM_HW_THREADS);
    localparam int DELTA_W = DATA_W + $clog2(NODES_IN_GRAPH);
    localparam int BEAT_W  = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1;
    localparam int NODE_W  = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;

    localparam logic [DATA_W-1:0] ONE_D     = DATA_W'(one_val(FRAC_W));
    localparam logic [DATA_W-1:0] RECIP_D   = DATA_W'(recip_n(FRAC_W, NODES_IN_GRAPH));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_HW_THREADS - 1);
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NODES_IN_GRAPH - 1);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [NODE_W-1:0]   node_idx_q, node_idx_d;
    logic [ACC_W-1:0]    acc_q [NODES_IN_GRAPH];
    logic [ACC_W-1:0]    acc_d [NODES_IN_GRAPH];
    logic [DATA_W-1:0]   rank_q [NODES_IN_GRAPH];
    logic [DATA_W-1:0]   rank_d [NODES_IN_GRAPH];
    logic [DATA_W-1:0]   damp_q, damp_d;
    logic [DELTA_W-1:0]  eps_q, eps_d;
    logic [DELTA_W-1:0]  delta_q, delta_d;
    logic                converged_q, converged_d;
    logic                complete_q, complete_d;
    logic [ITER_W-1:0]   iter_count_q, iter_count_d;

    logic [DATA_W-1:0]   lane_new;
    logic [DATA_W-1:0]   lane_diff;

    pagerank_damp_lane #(
        .DATA_W         (DATA_W),
        .FRAC_W         (FRAC_W),
        .ACC_W          (ACC_W),
        .NODES_IN_GRAPH (NODES_IN_GRAPH)
    ) u_lane (
        .damp     (damp_q),
        .acc      (acc_q[node_idx_q]),
        .old_rank (rank_q[node_idx_q]),
        .new_rank (lane_new),
        .diff     (lane_diff)
    );

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        node_idx_d   = node_idx_q;
        acc_d        = acc_q;
        rank_d       = rank_q;
        damp_d       = damp_q;
        eps_d        = eps_q;
        delta_d      = delta_q;
        converged_d  = converged_q;
        complete_d   = 1'b0;
        iter_count_d = iter_count_q;

        case (state_q)
            IDLE: begin
                if (iter_start) begin
                    for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                        acc_d[i] = '0;
                    end
                    beat_cnt_d = '0;
                    node_idx_d = '0;
                    delta_d    = '0;
                    damp_d     = (damping_factor > ONE_D) ? ONE_D : damping_factor;
                    eps_d      = epsilon;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                        acc_d[i] = acc_q[i] + ACC_W'(in_data[i]);
                    end
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        node_idx_d = '0;
                        state_d    = DAMP;
                    end
                end
            end
            DAMP: begin
                // Delta is taken against the rank value before this cycle's update.
                rank_d[node_idx_q] = lane_new;
                delta_d = DELTA_W'(sat(wide_t'(delta_q) + wide_t'(lane_diff), DELTA_W));
                if (node_idx_q == LAST_NODE) begin
                    state_d = DONE;
                end else begin
                    node_idx_d = node_idx_q + 1'b1;
                end
            end
            DONE: begin
                complete_d   = 1'b1;
                converged_d  = (delta_q <= eps_q);
                iter_count_d = iter_count_q + 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            node_idx_q   <= '0;
            damp_q       <= '0;
            eps_q        <= '0;
            delta_q      <= '0;
            converged_q  <= 1'b0;
            complete_q   <= 1'b0;
            iter_count_q <= '0;
            for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                acc_q[i]  <= '0;
                rank_q[i] <= RECIP_D;
            end
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            node_idx_q   <= node_idx_d;
            damp_q       <= damp_d;
            eps_q        <= eps_d;
            delta_q      <= delta_d;
            converged_q  <= converged_d;
            complete_q   <= complete_d;
            iter_count_q <= iter_count_d;
            acc_q        <= acc_d;
            rank_q       <= rank_d;
        end
    end

    assign in_ready           = (state_q == ACCUM);
    assign pagerank_final     = rank_q;
    assign delta              = delta_q;
    assign converged          = converged_q;
    assign iteration_complete = complete_q;
    assign iter_count         = iter_count_q;

endmodule
